// File: rtl/ras_pkg.sv
// Shared definitions for the RAS sequencer/arbiter.
//   ras_state_t : sequencer state (IDLE pass-through, REWIND pointer restore)
//   DEF_SIZE_RAS / DEF_SIZE_CKPT : default RAS depth and checkpoint slot count
//   ras_dist    : (a - b) mod size for power-of-two sizes
package ras_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REWIND = 1'b1
    } ras_state_t;

    localparam int DEF_SIZE_RAS  = 16;
    localparam int DEF_SIZE_CKPT = 8;

    // Forward distance from b to a on a ring of 'size' entries (size a power of two).
    function automatic int unsigned ras_dist(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned size);
        return (a - b) & (size - 1);
    endfunction

endpackage

// File: rtl/ras_ckpt_table.sv
// Checkpoint FIFO of RAS top-of-stack pointers, one slot per in-flight branch.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (clears head/tail/count)
//   alloc           : request to allocate a slot at head (already qualified by caller)
//   alloc_val       : TOS value written into the allocated slot
//   free            : retire the oldest slot (ignored when empty)
//   squash          : execute misprediction; discards all slots younger than squash_id
//   squash_id       : checkpoint id of the mispredicted branch, also the read address
//   rd_val          : TOS value stored in slot squash_id
//   head            : id the next allocation will receive
//   full            : all slots in use
module ras_ckpt_table
    import ras_pkg::*;
#(
    parameter int SIZE_RAS_LOG  = 4,
    parameter int SIZE_CKPT     = DEF_SIZE_CKPT,
    parameter int SIZE_CKPT_LOG = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc,
    input  logic [SIZE_RAS_LOG-1:0]  alloc_val,
    input  logic                     free,
    input  logic                     squash,
    input  logic [SIZE_CKPT_LOG-1:0] squash_id,
    output logic [SIZE_RAS_LOG-1:0]  rd_val,
    output logic [SIZE_CKPT_LOG-1:0] head,
    output logic                     full
);

    localparam int CNT_W = SIZE_CKPT_LOG + 1;

    logic [SIZE_RAS_LOG-1:0]  slots [SIZE_CKPT];
    logic [SIZE_CKPT_LOG-1:0] head_q;
    logic [SIZE_CKPT_LOG-1:0] tail_q;
    logic [CNT_W-1:0]         count_q;
    logic                     free_ok;
    logic                     alloc_ok;

    assign full    = (count_q == CNT_W'(SIZE_CKPT));
    assign free_ok = free && (count_q != '0);
    // A free in the same cycle releases the tail slot (which is the head slot when
    // full), so a full table still accepts an allocation paired with a free.
    assign alloc_ok = alloc && !squash && (!full || free_ok);

    assign head   = head_q;
    assign rd_val = slots[squash_id];

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (free_ok) begin
                tail_q <= tail_q + 1'b1;
            end
            if (squash) begin
                // Keep the mispredicted branch's slot and everything older than it.
                head_q  <= squash_id + 1'b1;
                count_q <= CNT_W'(ras_dist(32'(squash_id), 32'(tail_q), SIZE_CKPT) + 32'd1)
                           - CNT_W'(free_ok);
            end else begin
                if (alloc_ok) begin
                    head_q <= head_q + 1'b1;
                end
                count_q <= count_q + CNT_W'(alloc_ok) - CNT_W'(free_ok);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            slots[head_q] <= alloc_val;
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Sequencer/arbiter in front of the fetch-stage return address stack.
// Merges fetch call/return and decode recovery into the RAS push/pop port,
// checkpoints the RAS TOS per branch and rewinds TOS one pop per cycle after
// an execute misprediction while stalling fetch.
// Ports:
//   clk, reset                          : clock, synchronous active-low reset
//   fetchValid_i/fetchCall_i/fetchRtr_i : fetch bundle and predicted call/return
//   fetchPushAddr_i                     : return address pushed for a call
//   ckptAlloc_i/ckptId_o/ckptFull_o     : checkpoint allocation, id given, table full
//   ckptFree_i                          : retire oldest checkpoint
//   recoverID_i/callID_i/rtrID_i        : decode-stage recovery info
//   callPCID_i/callPCID_o               : decoded call PC, forwarded to the RAS
//   recoverEX_i/recoverEXId_i           : execute misprediction and its checkpoint
//   push_o/pop_o/pushAddr_o             : RAS command port
//   flagRecoverID_o/flagCallID_o/flagRtrID_o : RAS decode-recovery controls
//   stall_o                             : fetch must hold
// Optional build macro RAS_CTRL_PERF_EN adds rewindCycles_o and ckptFullCycles_o
// (32-bit saturating event counters, cleared on reset).
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int SIZE_PC       = 32,
    parameter int SIZE_RAS      = DEF_SIZE_RAS,
    parameter int SIZE_RAS_LOG  = 4,
    parameter int SIZE_CKPT     = DEF_SIZE_CKPT,
    parameter int SIZE_CKPT_LOG = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetchValid_i,
    input  logic                     fetchCall_i,
    input  logic                     fetchRtr_i,
    input  logic [SIZE_PC-1:0]       fetchPushAddr_i,
    input  logic                     ckptAlloc_i,
    output logic [SIZE_CKPT_LOG-1:0] ckptId_o,
    output logic                     ckptFull_o,
    input  logic                     ckptFree_i,
    input  logic                     recoverID_i,
    input  logic                     callID_i,
    input  logic                     rtrID_i,
    input  logic [SIZE_PC-1:0]       callPCID_i,
    input  logic                     recoverEX_i,
    input  logic [SIZE_CKPT_LOG-1:0] recoverEXId_i,
    output logic                     push_o,
    output logic                     pop_o,
    output logic [SIZE_PC-1:0]       pushAddr_o,
    output logic                     flagRecoverID_o,
    output logic                     flagCallID_o,
    output logic                     flagRtrID_o,
    output logic [SIZE_PC-1:0]       callPCID_o,
    output logic                     stall_o
`ifdef RAS_CTRL_PERF_EN
    ,
    output logic [31:0]              rewindCycles_o,
    output logic [31:0]              ckptFullCycles_o
`endif
);

    ras_state_t              state_q;
    ras_state_t              state_d;
    logic [SIZE_RAS_LOG-1:0] tos_sh;
    logic [SIZE_RAS_LOG-1:0] tos_cp_sh;
    logic [SIZE_RAS_LOG-1:0] tos_base;
    logic [SIZE_RAS_LOG-1:0] tos_next;
    logic [SIZE_RAS_LOG-1:0] target_q;
    logic [SIZE_RAS_LOG-1:0] ckpt_val;
    logic                    sh_push;
    logic                    sh_pop;
    logic                    alloc_req;

    // Command muxing and next state. Everything is held off while reset is low.
    always_comb begin
        state_d         = state_q;
        push_o          = 1'b0;
        pop_o           = 1'b0;
        pushAddr_o      = '0;
        flagRecoverID_o = 1'b0;
        flagCallID_o    = 1'b0;
        flagRtrID_o     = 1'b0;
        callPCID_o      = '0;
        stall_o         = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (recoverEX_i) begin
                        // Misprediction outranks decode and fetch; rewind only if TOS moved.
                        if (ras_dist(32'(tos_sh), 32'(ckpt_val), SIZE_RAS) != 0) begin
                            state_d = REWIND;
                        end
                    end else begin
                        push_o          = fetchValid_i & fetchCall_i & ~recoverID_i;
                        pop_o           = fetchValid_i & fetchRtr_i & ~recoverID_i;
                        flagRecoverID_o = recoverID_i;
                        flagCallID_o    = callID_i;
                        flagRtrID_o     = rtrID_i;
                        callPCID_o      = callPCID_i;
                        if (fetchValid_i & fetchCall_i & ~recoverID_i) begin
                            pushAddr_o = fetchPushAddr_i;
                        end
                    end
                end
                REWIND: begin
                    stall_o = 1'b1;
                    pop_o   = (tos_sh != target_q);
                    // A new misprediction reloads the target, so stay to re-evaluate.
                    if (!recoverEX_i && (tos_sh == target_q)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shadow pointer follows the RAS rule exactly, including decode recovery.
    assign tos_base = flagRecoverID_o ? tos_cp_sh : tos_sh;
    assign sh_push  = push_o | (flagRecoverID_o & flagCallID_o);
    assign sh_pop   = pop_o | (flagRecoverID_o & flagRtrID_o);
    assign tos_next = tos_base + SIZE_RAS_LOG'(sh_push) - SIZE_RAS_LOG'(sh_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tos_sh    <= '0;
            tos_cp_sh <= '0;
        end else begin
            state_q   <= state_d;
            tos_sh    <= tos_next;
            tos_cp_sh <= flagRecoverID_o ? tos_next : tos_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (recoverEX_i) begin
            target_q <= ckpt_val;
        end
    end

    // Fetch-side allocation is ignored while rewinding or when a misprediction lands.
    assign alloc_req = ckptAlloc_i & (state_q == IDLE) & ~recoverEX_i & reset;

    ras_ckpt_table #(
        .SIZE_RAS_LOG  (SIZE_RAS_LOG),
        .SIZE_CKPT     (SIZE_CKPT),
        .SIZE_CKPT_LOG (SIZE_CKPT_LOG)
    ) u_ckpt (
        .clk       (clk),
        .reset     (reset),
        .alloc     (alloc_req),
        .alloc_val (tos_next),
        .free      (ckptFree_i),
        .squash    (recoverEX_i),
        .squash_id (recoverEXId_i),
        .rd_val    (ckpt_val),
        .head      (ckptId_o),
        .full      (ckptFull_o)
    );

`ifdef RAS_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rewindCycles_o   <= '0;
            ckptFullCycles_o <= '0;
        end else begin
            if ((state_q == REWIND) && (rewindCycles_o != '1)) begin
                rewindCycles_o <= rewindCycles_o + 1'b1;
            end
            if (ckptFull_o && ckptAlloc_i && (ckptFullCycles_o != '1)) begin
                ckptFullCycles_o <= ckptFullCycles_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencer and arbiter in front of the fetch-stage return address stack (RAS). It merges fetch-stage call/return requests and decode-stage recovery into the RAS's single push/pop command port. It checkpoints the RAS top-of-stack (TOS) pointer per in-flight branch. On execute-stage misprediction it rewinds the RAS to the checkpointed TOS by issuing one pop per cycle while stalling fetch.

## Interface
Parameters:
- SIZE_PC, 32, PC width
- SIZE_RAS, 16, RAS depth (power of two)
- SIZE_RAS_LOG, 4, log2(SIZE_RAS)
- SIZE_CKPT, 8, checkpoint slots (power of two)
- SIZE_CKPT_LOG, 3, log2(SIZE_CKPT)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-low
- fetchValid_i  in  1  fetch bundle valid
- fetchCall_i / fetchRtr_i  in  1  predicted call / return in bundle
- fetchPushAddr_i  in  SIZE_PC  return address for call
- ckptAlloc_i  in  1  allocate checkpoint for fetched branch
- ckptId_o  out  SIZE_CKPT_LOG  id of slot allocated this cycle
- ckptFull_o  out  1  no free slot
- ckptFree_i  in  1  retire oldest checkpoint
- recoverID_i, callID_i, rtrID_i  in  1  decode-stage recovery info
- callPCID_i  in  SIZE_PC  PC of decoded call
- recoverEX_i  in  1  execute misprediction
- recoverEXId_i  in  SIZE_CKPT_LOG  checkpoint of mispredicted branch
- push_o, pop_o  out  1  RAS command
- pushAddr_o  out  SIZE_PC  RAS push data
- flagRecoverID_o, flagCallID_o, flagRtrID_o  out  1  RAS decode-recovery controls
- callPCID_o  out  SIZE_PC  forwarded call PC
- stall_o  out  1  fetch must hold

## Operation
- Shadow state mirrors the RAS pointer exactly: tosSh, tosCPSh, same next-state rule as the RAS.
  - recoverID selects tosCPSh as the base; otherwise tosSh is the base.
  - push: base+1. pop: base−1. Arithmetic is mod SIZE_RAS.
  - tosCPSh ← next tos when recoverID; otherwise tosCPSh ← current tosSh.
- States:
  - IDLE: commands pass through. push_o = fetchValid&fetchCall&~recoverID_i. pop_o = fetchValid&fetchRtr&~recoverID_i. The ID flags are forwarded unchanged. stall_o=0.
  - REWIND: ID and fetch inputs are ignored. All ID flag outputs and push_o are 0. pop_o=1 while tosSh≠target. stall_o=1.
- Transitions:
  - IDLE→REWIND on recoverEX_i. target ← ckpt[recoverEXId_i].
  - If tosSh already equals target, the FSM stays in IDLE. No pops are issued.
  - REWIND→IDLE in the cycle after tosSh reaches target.
  - recoverEX_i during REWIND reloads target and continues from the current tosSh.
- Priority: recoverEX > recoverID > fetch.
- Checkpoint table (circular FIFO, head/tail/count):
  - On ckptAlloc_i & ~ckptFull_o: ckpt[head] ← tos value after this cycle's command; ckptId_o = head; head++.
  - Alloc while full is dropped.
  - ckptFree_i with count=0 is ignored.
  - recoverEX_i squashes younger slots: head ← recoverEXId_i+1, and count is recomputed from tail.
  - Alloc and free in the same cycle leave count unchanged.
- Stack contents are not repaired. Only TOS is restored.

## Timing
- Reset (reset=0 at edge): tosSh=tosCPSh=0, head=tail=count=0, state IDLE. All outputs are 0 except ckptId_o=0.
- IDLE commands are combinational, zero latency. The RAS samples them at the same edge as the shadow.
- Rewind cost is a cycles-of-pop count, d = (tosSh − target) mod SIZE_RAS, with d ≤ SIZE_RAS−1.
  - stall_o is high for d+1 cycles, starting the cycle after recoverEX_i.
  - pop_o is high for the first d of those cycles.
- Wrap-around: target > tosSh pops through index 0 to SIZE_RAS−1.
- Reset asserted mid-REWIND aborts it. The block is in IDLE next cycle.

## Configuration
- RAS_CTRL_PERF_EN defined:
  - Adds rewindCycles_o (32-bit), which counts REWIND cycles.
  - Adds ckptFullCycles_o (32-bit), which counts cycles with ckptFull_o & ckptAlloc_i.
  - Both counters clear on reset and saturate.
- RAS_CTRL_PERF_EN undefined: the ports and counters are absent.

## Structure
- Shared package ras_pkg holds:
  - the FSM state enum (IDLE, REWIND)
  - default SIZE_RAS and SIZE_CKPT constants
  - the mod-SIZE_RAS distance function
- Sub-module ras_ckpt_table holds the checkpoint FIFO: storage, head/tail/count, squash.
- The top level holds the shadow TOS, the FSM and the output muxing.

## Test plan
- Reset then 3 fetch calls: push_o for 3 cycles, tosSh=3, no stall.
- Call pushes (tos=5); alloc checkpoint id 0 (value 5); 3 more calls (tos=8); recoverEX id 0 → 3 pop cycles, stall_o for 4 cycles, tosSh=5, then IDLE.
- Wrap: checkpoint at tos=14; calls to tos=2; recoverEX → 4 pops through 1,0,15,14.
- recoverID with callID, tosCPSh=6 → push_o=0, flagCallID_o=1, tosSh=7, tosCPSh=7.
- Fill 8 checkpoints → ckptFull_o=1; 9th alloc dropped. ckptFree_i plus alloc in the same cycle keeps count=8.
- Second recoverEX mid-REWIND to an older slot: target reloads and extra pops occur. Reset mid-REWIND gives IDLE with pop_o=0 next cycle.
